// File: rtl/stopwatch_counter.sv
// Stopwatch core: 100 Hz tick to BCD MM:SS.cc with run/pause/lap/clear control.
// Latency: button press effective BTN_SYNC+1 clks after sampling; disp_bcd 1 clk after count.
// Backpressure: none; ticks outside RUN are dropped, never queued.
module stopwatch_counter #(
    parameter int MIN_LIMIT = 59,
    parameter int BTN_SYNC  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick_in,
    input  logic        start_stop,
    input  logic        lap_reset,
    output logic [23:0] disp_bcd,
    output logic        running,
    output logic        lap_active,
    output logic        wrap
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

    typedef struct packed {
        logic [3:0] min_t;
        logic [3:0] min_o;
        logic [3:0] sec_t;
        logic [3:0] sec_o;
        logic [3:0] cs_t;
        logic [3:0] cs_o;
    } bcd_t;

    localparam logic [3:0] MIN_LIM_T = 4'(MIN_LIMIT / 10);
    localparam logic [3:0] MIN_LIM_O = 4'(MIN_LIMIT % 10);

    state_t              state_q, state_d;
    logic [BTN_SYNC-1:0] ss_sync, lr_sync;
    logic                ss_prev, lr_prev;
    logic                ss_edge, lr_edge;
    logic                tick_q, tick_rise;
    logic                count_inc, clear, lap_d, wrap_d;
    bcd_t                cnt_q, cnt_d, lap_q;

    // Button path: synchronizer, then a registered rising-edge pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ss_sync <= '0;
            lr_sync <= '0;
            ss_prev <= 1'b0;
            lr_prev <= 1'b0;
            ss_edge <= 1'b0;
            lr_edge <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            ss_sync <= {ss_sync[BTN_SYNC-2:0], start_stop};
            lr_sync <= {lr_sync[BTN_SYNC-2:0], lap_reset};
            ss_prev <= ss_sync[BTN_SYNC-1];
            lr_prev <= lr_sync[BTN_SYNC-1];
            ss_edge <= ss_sync[BTN_SYNC-1] & ~ss_prev;
            lr_edge <= lr_sync[BTN_SYNC-1] & ~lr_prev;
            tick_q  <= tick_in;
        end
    end

    assign tick_rise = tick_in & ~tick_q;
    // The tick is judged against the pre-transition state.
    assign count_inc = (state_q == RUN) & tick_rise;

    always_comb begin
        state_d = state_q;
        lap_d   = lap_active;
        clear   = 1'b0;
        case (state_q)
            IDLE: begin
                if (ss_edge) state_d = RUN;
            end
            RUN: begin
                if (ss_edge)      state_d = PAUSE;
                else if (lr_edge) lap_d = ~lap_active;
            end
            PAUSE: begin
                if (ss_edge) begin
                    state_d = RUN;
                end else if (lr_edge) begin
                    state_d = IDLE;
                    lap_d   = 1'b0;
                    clear   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        if (clear) begin
            cnt_d = '0;
        end else if (count_inc) begin
            if (cnt_q.cs_o != 4'd9) begin
                cnt_d.cs_o = cnt_q.cs_o + 4'd1;
            end else begin
                cnt_d.cs_o = 4'd0;
                if (cnt_q.cs_t != 4'd9) begin
                    cnt_d.cs_t = cnt_q.cs_t + 4'd1;
                end else begin
                    cnt_d.cs_t = 4'd0;
                    if (cnt_q.sec_o != 4'd9) begin
                        cnt_d.sec_o = cnt_q.sec_o + 4'd1;
                    end else begin
                        cnt_d.sec_o = 4'd0;
                        if (cnt_q.sec_t != 4'd5) begin
                            cnt_d.sec_t = cnt_q.sec_t + 4'd1;
                        end else begin
                            cnt_d.sec_t = 4'd0;
                            if (cnt_q.min_t == MIN_LIM_T && cnt_q.min_o == MIN_LIM_O) begin
                                cnt_d.min_t = 4'd0;
                                cnt_d.min_o = 4'd0;
                                wrap_d      = 1'b1;
                            end else if (cnt_q.min_o != 4'd9) begin
                                cnt_d.min_o = cnt_q.min_o + 4'd1;
                            end else begin
                                cnt_d.min_o = 4'd0;
                                cnt_d.min_t = cnt_q.min_t + 4'd1;
                            end
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            lap_q      <= '0;
            lap_active <= 1'b0;
            running    <= 1'b0;
            wrap       <= 1'b0;
            disp_bcd   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            lap_active <= lap_d;
            running    <= (state_d == RUN);
            wrap       <= wrap_d;
            disp_bcd   <= lap_active ? lap_q : cnt_q;
            // Lap captures the count as it stands after this edge's tick.
            if (clear)                     lap_q <= '0;
            else if (lap_d && !lap_active) lap_q <= cnt_d;
        end
    end

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed bench for stopwatch_counter; MIN_LIMIT=2 keeps the full-wrap run short.
module tb_stopwatch_counter;

    logic        clk = 1'b0;
    logic        rst;
    logic        tick_in;
    logic        start_stop;
    logic        lap_reset;
    logic [23:0] disp_bcd;
    logic        running;
    logic        lap_active;
    logic        wrap;

    int tests  = 0;
    int failed = 0;

    stopwatch_counter #(.MIN_LIMIT(2), .BTN_SYNC(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .tick_in    (tick_in),
        .start_stop (start_stop),
        .lap_reset  (lap_reset),
        .disp_bcd   (disp_bcd),
        .running    (running),
        .lap_active (lap_active),
        .wrap       (wrap)
    );

    always #5 clk = ~clk;

    task automatic press(input logic ss, input logic lr);
        @(posedge clk); #1;
        start_stop = ss;
        lap_reset  = lr;
        repeat (6) @(posedge clk);
        #1;
        start_stop = 1'b0;
        lap_reset  = 1'b0;
        repeat (6) @(posedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1 tick_in = 1'b1;
            @(posedge clk); #1 tick_in = 1'b0;
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1; tick_in = 1'b0; start_stop = 1'b0; lap_reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++; if (disp_bcd !== 24'h000000) begin failed++; $display("FAIL reset_disp: got %h want 000000", disp_bcd); end
        tests++; if (running !== 1'b0) begin failed++; $display("FAIL reset_running: got %b want 0", running); end
        tests++; if (lap_active !== 1'b0) begin failed++; $display("FAIL reset_lap: got %b want 0", lap_active); end
        tests++; if (wrap !== 1'b0) begin failed++; $display("FAIL reset_wrap: got %b want 0", wrap); end
        @(posedge clk); #1 rst = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_run;
        @(posedge clk); #1 start_stop = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++; if (running !== 1'b0) begin failed++; $display("FAIL btn_latency_early: running=%b want 0", running); end
        @(posedge clk);
        @(negedge clk);
        tests++; if (running !== 1'b1) begin failed++; $display("FAIL btn_latency: running=%b want 1", running); end
        @(posedge clk); #1 start_stop = 1'b0;
        repeat (4) @(posedge clk);
        ticks(100);
        @(negedge clk);
        tests++; if (disp_bcd !== 24'h000100) begin failed++; $display("FAIL run_1s: got %h want 000100", disp_bcd); end
        tests++; if (running !== 1'b1) begin failed++; $display("FAIL run_running: got %b want 1", running); end
        ticks(6000);
        @(negedge clk);
        tests++; if (disp_bcd !== 24'h010100) begin failed++; $display("FAIL run_61s: got %h want 010100", disp_bcd); end
    endtask

    task automatic test_wrap;
        int highs;
        ticks(11899);
        @(negedge clk);
        tests++; if (disp_bcd !== 24'h025999) begin failed++; $display("FAIL wrap_max: got %h want 025999", disp_bcd); end
        @(posedge clk); #1 tick_in = 1'b1;
        @(negedge clk);
        tests++; if (wrap !== 1'b0) begin failed++; $display("FAIL wrap_early: got %b want 0", wrap); end
        @(posedge clk); #1 tick_in = 1'b0;
        @(negedge clk);
        tests++; if (wrap !== 1'b1) begin failed++; $display("FAIL wrap_pulse: got %b want 1", wrap); end
        @(negedge clk);
        tests++; if (disp_bcd !== 24'h000000) begin failed++; $display("FAIL wrap_disp: got %h want 000000", disp_bcd); end
        highs = 0;
        for (int i = 0; i < 6; i++) begin
            if (wrap === 1'b1) highs++;
            @(negedge clk);
        end
        tests++; if (highs != 0) begin failed++; $display("FAIL wrap_width: extra high clks %0d want 0", highs); end
    endtask

    task automatic test_lap;
        ticks(250);
        press(1'b0, 1'b1);
        @(negedge clk);
        tests++; if (lap_active !== 1'b1) begin failed++; $display("FAIL lap_on: got %b want 1", lap_active); end
        tests++; if (disp_bcd !== 24'h000250) begin failed++; $display("FAIL lap_hold: got %h want 000250", disp_bcd); end
        ticks(30);
        @(negedge clk);
        tests++; if (disp_bcd !== 24'h000250) begin failed++; $display("FAIL lap_frozen: got %h want 000250", disp_bcd); end
        press(1'b0, 1'b1);
        @(negedge clk);
        tests++; if (lap_active !== 1'b0) begin failed++; $display("FAIL lap_off: got %b want 0", lap_active); end
        tests++; if (disp_bcd !== 24'h000280) begin failed++; $display("FAIL lap_live: got %h want 000280", disp_bcd); end
    endtask

    task automatic test_pause;
        press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        @(negedge clk);
        tests++; if (disp_bcd !== 24'h000000) begin failed++; $display("FAIL clear_first: got %h want 000000", disp_bcd); end
        press(1'b1, 1'b0);
        ticks(42);
        press(1'b1, 1'b0);
        @(negedge clk);
        tests++; if (running !== 1'b0) begin failed++; $display("FAIL pause_running: got %b want 0", running); end
        ticks(10);
        @(negedge clk);
        tests++; if (disp_bcd !== 24'h000042) begin failed++; $display("FAIL pause_drop: got %h want 000042", disp_bcd); end
        press(1'b0, 1'b1);
        @(negedge clk);
        tests++; if (disp_bcd !== 24'h000000) begin failed++; $display("FAIL pause_clear: got %h want 000000", disp_bcd); end
        press(1'b0, 1'b1);
        ticks(5);
        @(negedge clk);
        tests++; if (disp_bcd !== 24'h000000) begin failed++; $display("FAIL idle_lap: got %h want 000000", disp_bcd); end
        tests++; if (running !== 1'b0 || lap_active !== 1'b0) begin failed++; $display("FAIL idle_state: running=%b lap=%b want 0 0", running, lap_active); end
    endtask

    task automatic test_simultaneous;
        press(1'b1, 1'b0);
        ticks(7);
        press(1'b0, 1'b1);
        press(1'b1, 1'b1);
        @(negedge clk);
        tests++; if (running !== 1'b0) begin failed++; $display("FAIL both_pause: running=%b want 0", running); end
        tests++; if (lap_active !== 1'b1) begin failed++; $display("FAIL both_lap_kept: got %b want 1", lap_active); end
        press(1'b1, 1'b0);
        @(negedge clk);
        tests++; if (lap_active !== 1'b1) begin failed++; $display("FAIL resume_lap_kept: got %b want 1", lap_active); end
        press(1'b0, 1'b1);
        @(posedge clk); #1 tick_in = 1'b1;
        repeat (50) @(posedge clk);
        #1 tick_in = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++; if (disp_bcd !== 24'h000008) begin failed++; $display("FAIL held_tick: got %h want 000008", disp_bcd); end
    endtask

    task automatic test_tick_on_pause;
        @(posedge clk); #1 start_stop = 1'b1;
        repeat (3) @(posedge clk);
        #1 tick_in = 1'b1;
        @(posedge clk); #1 tick_in = 1'b0;
        repeat (4) @(posedge clk);
        #1 start_stop = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        tests++; if (running !== 1'b0) begin failed++; $display("FAIL edge_pause: running=%b want 0", running); end
        tests++; if (disp_bcd !== 24'h000009) begin failed++; $display("FAIL edge_tick_counted: got %h want 000009", disp_bcd); end
    endtask

    task automatic test_reset_mid;
        press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        ticks(3);
        @(posedge clk); #1 start_stop = 1'b1;
        @(posedge clk); #2 rst = 1'b1;
        #1;
        tests++; if (disp_bcd !== 24'h000000) begin failed++; $display("FAIL mid_reset_disp: got %h want 000000", disp_bcd); end
        tests++; if (running !== 1'b0 || lap_active !== 1'b0 || wrap !== 1'b0) begin failed++; $display("FAIL mid_reset_flags: running=%b lap=%b wrap=%b want 0 0 0", running, lap_active, wrap); end
        start_stop = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        tests++; if (running !== 1'b0) begin failed++; $display("FAIL no_pending_edge: running=%b want 0", running); end
        tests++; if (disp_bcd !== 24'h000000) begin failed++; $display("FAIL post_reset_disp: got %h want 000000", disp_bcd); end
    endtask

    initial begin
        test_reset();
        test_run();
        test_wrap();
        test_lap();
        test_pause();
        test_simultaneous();
        test_tick_on_pause();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
